// File: rtl/nibble_and_sched_pkg.sv
// Shared types and constants for nibble_and_sched.
// Lane count is set by NIBBLE_AND_SCHED_DUAL_LANE_EN (defined: 2 lanes, undefined: 1 lane).
package nibble_and_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIB_W = 4;

`ifdef NIBBLE_AND_SCHED_DUAL_LANE_EN
    localparam int unsigned LANES = 2;
`else
    localparam int unsigned LANES = 1;
`endif

endpackage

// File: rtl/nibble_and_lane.sv
// Shared 4-bit AND lane: one result nibble per use.
module nibble_and_lane
    import nibble_and_sched_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic [NIB_W-1:0] o
);

    assign o = a & b;

endmodule

// File: rtl/nibble_and_sched.sv
// Time-multiplexed nibble AND: result nibble k = op nibble k & op nibble (k+1) mod N,
// computed LANES nibbles per cycle by shared nibble_and_lane instances.
module nibble_and_sched
    import nibble_and_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned N     = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    // Nibble index shifted by 2 addresses bits; clog2(4N) == clog2(N) + 2.
    localparam int unsigned BIT_W = IDX_W + 2;

    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - LANES);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] w_op_nxt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_nxt;

    logic [IDX_W-1:0] w_pos    [LANES];
    logic [IDX_W-1:0] w_pos_nx [LANES];
    logic [BIT_W-1:0] w_bit    [LANES];
    logic [BIT_W-1:0] w_bit_nx [LANES];
    logic [NIB_W-1:0] w_lane_a [LANES];
    logic [NIB_W-1:0] w_lane_b [LANES];
    logic [NIB_W-1:0] w_lane_o [LANES];

    // Operand selection for each lane; the last nibble pairs with nibble 0.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_pos[l]    = r_idx + IDX_W'(l);
            w_pos_nx[l] = (w_pos[l] == MAX_IDX) ? '0 : w_pos[l] + IDX_W'(1);
            w_bit[l]    = {w_pos[l], 2'b00};
            w_bit_nx[l] = {w_pos_nx[l], 2'b00};
            w_lane_a[l] = r_op[w_bit[l] +: NIB_W];
            w_lane_b[l] = r_op[w_bit_nx[l] +: NIB_W];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        nibble_and_lane u_lane (
            .a (w_lane_a[g]),
            .b (w_lane_b[g]),
            .o (w_lane_o[g])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_op_nxt    = r_op;
        w_res_nxt   = r_res;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_op_nxt    = in_data;
                    w_res_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    w_res_nxt[w_bit[l] +: NIB_W] = w_lane_o[l];
                end
                // Index parks on the last position; it never wraps past N-1.
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt = r_idx + IDX_STEP;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_op    <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_op    <= w_op_nxt;
            r_res   <= w_res_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign out_data  = r_res;

endmodule
